// File: rtl/axi_mst_port_arb.sv
// Arbitrates AW and AR requests from several slave-side paths onto one crossbar master port.
// A W-order FIFO of granted AW indices steers W bursts in the order their addresses were accepted.
module axi_mst_port_arb #(
    parameter int unsigned NoSlvPorts = 4,
    parameter int unsigned MaxWTrans  = 4,
    localparam int unsigned IdxWidth  = $clog2(NoSlvPorts)
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [NoSlvPorts-1:0] aw_valid_i,
    output logic [NoSlvPorts-1:0] aw_ready_o,
    output logic                  mst_aw_valid_o,
    input  logic                  mst_aw_ready_i,
    output logic [IdxWidth-1:0]   mst_aw_sel_o,
    input  logic [NoSlvPorts-1:0] w_valid_i,
    input  logic [NoSlvPorts-1:0] w_last_i,
    output logic [NoSlvPorts-1:0] w_ready_o,
    output logic                  mst_w_valid_o,
    output logic                  mst_w_last_o,
    input  logic                  mst_w_ready_i,
    output logic [IdxWidth-1:0]   mst_w_sel_o,
    input  logic [NoSlvPorts-1:0] ar_valid_i,
    output logic [NoSlvPorts-1:0] ar_ready_o,
    output logic                  mst_ar_valid_o,
    input  logic                  mst_ar_ready_i,
    output logic [IdxWidth-1:0]   mst_ar_sel_o,
    output logic                  fifo_full_o
);

    localparam int unsigned PtrWidth = (MaxWTrans > 1) ? $clog2(MaxWTrans) : 1;
    localparam int unsigned CntWidth = $clog2(MaxWTrans + 1);

    // First requester at or after ptr, wrapping around; index 0 when nobody requests.
    function automatic logic [IdxWidth-1:0] rr_pick(input logic [NoSlvPorts-1:0] req,
                                                     input logic [IdxWidth-1:0]   ptr);
        logic        found;
        int unsigned idx;
        rr_pick = '0;
        found   = 1'b0;
        for (int unsigned i = 0; i < NoSlvPorts; i++) begin
            idx = (32'(ptr) + i) % NoSlvPorts;
            if (!found && req[IdxWidth'(idx)]) begin
                rr_pick = IdxWidth'(idx);
                found   = 1'b1;
            end
        end
    endfunction

    function automatic logic [IdxWidth-1:0] next_idx(input logic [IdxWidth-1:0] idx);
        next_idx = (idx == IdxWidth'(NoSlvPorts - 1)) ? '0 : idx + 1'b1;
    endfunction

    function automatic logic [PtrWidth-1:0] next_slot(input logic [PtrWidth-1:0] slot);
        next_slot = (slot == PtrWidth'(MaxWTrans - 1)) ? '0 : slot + 1'b1;
    endfunction

    logic [IdxWidth-1:0] aw_ptr, aw_lock_idx, aw_grant;
    logic                aw_locked, aw_hs;
    logic [IdxWidth-1:0] ar_ptr, ar_lock_idx, ar_grant;
    logic                ar_locked, ar_hs;

    logic [IdxWidth-1:0] fifo_mem [MaxWTrans];
    logic [PtrWidth-1:0] wr_ptr, rd_ptr;
    logic [CntWidth-1:0] fifo_cnt;
    logic                fifo_full, fifo_empty, w_pop;
    logic [IdxWidth-1:0] head;

    assign fifo_full   = (fifo_cnt == CntWidth'(MaxWTrans));
    assign fifo_empty  = (fifo_cnt == '0);
    assign fifo_full_o = fifo_full;
    assign head        = fifo_mem[rd_ptr];

    // A pending (valid without ready) request keeps its grant until it handshakes.
    assign aw_grant       = aw_locked ? aw_lock_idx : rr_pick(aw_valid_i, aw_ptr);
    assign mst_aw_valid_o = |aw_valid_i & ~fifo_full;
    assign mst_aw_sel_o   = aw_grant;
    assign aw_hs          = mst_aw_valid_o & mst_aw_ready_i;

    assign ar_grant       = ar_locked ? ar_lock_idx : rr_pick(ar_valid_i, ar_ptr);
    assign mst_ar_valid_o = |ar_valid_i;
    assign mst_ar_sel_o   = ar_grant;
    assign ar_hs          = mst_ar_valid_o & mst_ar_ready_i;

    always_comb begin
        aw_ready_o = '0;
        ar_ready_o = '0;
        for (int k = 0; k < NoSlvPorts; k++) begin
            aw_ready_o[k] = (aw_grant == IdxWidth'(k)) & mst_aw_ready_i & ~fifo_full;
            ar_ready_o[k] = (ar_grant == IdxWidth'(k)) & mst_ar_ready_i;
        end
    end

    always_comb begin
        mst_w_valid_o = 1'b0;
        mst_w_last_o  = 1'b0;
        mst_w_sel_o   = '0;
        w_ready_o     = '0;
        if (!fifo_empty) begin
            mst_w_sel_o     = head;
            mst_w_valid_o   = w_valid_i[head];
            mst_w_last_o    = w_last_i[head];
            w_ready_o[head] = mst_w_ready_i;
        end
    end

    assign w_pop = mst_w_valid_o & mst_w_ready_i & mst_w_last_o;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            aw_ptr      <= '0;
            aw_locked   <= 1'b0;
            aw_lock_idx <= '0;
        end else if (aw_hs) begin
            aw_ptr    <= next_idx(aw_grant);
            aw_locked <= 1'b0;
        end else if (mst_aw_valid_o) begin
            aw_locked   <= 1'b1;
            aw_lock_idx <= aw_grant;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ar_ptr      <= '0;
            ar_locked   <= 1'b0;
            ar_lock_idx <= '0;
        end else if (ar_hs) begin
            ar_ptr    <= next_idx(ar_grant);
            ar_locked <= 1'b0;
        end else if (mst_ar_valid_o) begin
            ar_locked   <= 1'b1;
            ar_lock_idx <= ar_grant;
        end
    end

    // Storage is not reset; occupancy alone decides which entries are meaningful.
    always_ff @(posedge clk_i) begin
        if (aw_hs) begin
            fifo_mem[wr_ptr] <= aw_grant;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_cnt <= '0;
        end else begin
            if (aw_hs) begin
                wr_ptr <= next_slot(wr_ptr);
            end
            if (w_pop) begin
                rd_ptr <= next_slot(rd_ptr);
            end
            case ({aw_hs, w_pop})
                2'b10:   fifo_cnt <= fifo_cnt + 1'b1;
                2'b01:   fifo_cnt <= fifo_cnt - 1'b1;
                default: fifo_cnt <= fifo_cnt;
            endcase
        end
    end

endmodule

// File: tb/tb_axi_mst_port_arb.sv
// Directed bench for axi_mst_port_arb: stimulus queues expected grants, a negedge
// monitor checks every AW/AR/W handshake against them in order.
module tb_axi_mst_port_arb;

    localparam int N = 4;
    localparam int M = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic [N-1:0] aw_valid, aw_ready, w_valid, w_last, w_ready, ar_valid, ar_ready;
    logic         mst_aw_valid, mst_aw_ready, mst_w_valid, mst_w_last, mst_w_ready;
    logic         mst_ar_valid, mst_ar_ready, fifo_full;
    logic [1:0]   mst_aw_sel, mst_w_sel, mst_ar_sel;

    int tests    = 0;
    int failures = 0;
    int exp_aw_q[$];
    int exp_ar_q[$];
    int exp_w_q[$];

    always #5 clk = ~clk;

    axi_mst_port_arb #(.NoSlvPorts(N), .MaxWTrans(M)) dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .aw_valid_i     (aw_valid),
        .aw_ready_o     (aw_ready),
        .mst_aw_valid_o (mst_aw_valid),
        .mst_aw_ready_i (mst_aw_ready),
        .mst_aw_sel_o   (mst_aw_sel),
        .w_valid_i      (w_valid),
        .w_last_i       (w_last),
        .w_ready_o      (w_ready),
        .mst_w_valid_o  (mst_w_valid),
        .mst_w_last_o   (mst_w_last),
        .mst_w_ready_i  (mst_w_ready),
        .mst_w_sel_o    (mst_w_sel),
        .ar_valid_i     (ar_valid),
        .ar_ready_o     (ar_ready),
        .mst_ar_valid_o (mst_ar_valid),
        .mst_ar_ready_i (mst_ar_ready),
        .mst_ar_sel_o   (mst_ar_sel),
        .fifo_full_o    (fifo_full)
    );

    function automatic logic [3:0] onehot(input int i);
        logic [1:0] b;
        b = i[1:0];
        onehot = '0;
        onehot[b] = 1'b1;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        tests++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0h, required %0h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic [3:0] awv, input logic awr,
                                 input logic [3:0] wv, input logic [3:0] wl, input logic wr,
                                 input logic [3:0] arv, input logic arr);
        aw_valid     = awv;
        mst_aw_ready = awr;
        w_valid      = wv;
        w_last       = wl;
        mst_w_ready  = wr;
        ar_valid     = arv;
        mst_ar_ready = arr;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // W expectations are encoded as sel*2 + last.
    always @(negedge clk) begin : monitor
        int e;
        if (!rst) begin
            if (mst_aw_valid && mst_aw_ready) begin
                tests++;
                if (exp_aw_q.size() == 0) begin
                    failures++;
                    $display("[TB] FAIL aw_handshake: got sel %0d, required no handshake", mst_aw_sel);
                end else begin
                    e = exp_aw_q.pop_front();
                    if (mst_aw_sel !== 2'(e) || aw_ready !== onehot(e)) begin
                        failures++;
                        $display("[TB] FAIL aw_grant: got sel %0d ready %b, required sel %0d ready %b",
                                 mst_aw_sel, aw_ready, e, onehot(e));
                    end
                end
            end
            if (mst_ar_valid && mst_ar_ready) begin
                tests++;
                if (exp_ar_q.size() == 0) begin
                    failures++;
                    $display("[TB] FAIL ar_handshake: got sel %0d, required no handshake", mst_ar_sel);
                end else begin
                    e = exp_ar_q.pop_front();
                    if (mst_ar_sel !== 2'(e) || ar_ready !== onehot(e)) begin
                        failures++;
                        $display("[TB] FAIL ar_grant: got sel %0d ready %b, required sel %0d ready %b",
                                 mst_ar_sel, ar_ready, e, onehot(e));
                    end
                end
            end
            if (mst_w_valid && mst_w_ready) begin
                tests++;
                if (exp_w_q.size() == 0) begin
                    failures++;
                    $display("[TB] FAIL w_handshake: got sel %0d, required no handshake", mst_w_sel);
                end else begin
                    e = exp_w_q.pop_front();
                    if (mst_w_sel !== 2'(e >> 1) || mst_w_last !== e[0] || w_ready !== onehot(e >> 1)) begin
                        failures++;
                        $display("[TB] FAIL w_beat: got sel %0d last %b ready %b, required sel %0d last %b ready %b",
                                 mst_w_sel, mst_w_last, w_ready, e >> 1, e[0], onehot(e >> 1));
                    end
                end
            end
        end
    end

    initial begin
        rst = 1'b1;
        applyStimulus(4'h0, 1'b0, 4'h0, 4'h0, 1'b0, 4'h0, 1'b0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        sample();
        checkOutput("reset_aw_valid", 32'(mst_aw_valid), 0);
        checkOutput("reset_w_valid", 32'(mst_w_valid), 0);
        checkOutput("reset_ar_valid", 32'(mst_ar_valid), 0);
        checkOutput("reset_fifo_full", 32'(fifo_full), 0);
        checkOutput("reset_sels", 32'({mst_aw_sel, mst_w_sel, mst_ar_sel}), 0);
        checkOutput("reset_readys", 32'({aw_ready, w_ready, ar_ready}), 0);
        tick();

        // All four request AW back to back: grants 0..3 fill the FIFO.
        for (int k = 0; k < 4; k++) begin
            applyStimulus(4'hF, 1'b1, 4'h0, 4'h0, 1'b0, 4'h0, 1'b0);
            exp_aw_q.push_back(k);
            sample();
            tick();
        end
        applyStimulus(4'hF, 1'b1, 4'h0, 4'h0, 1'b0, 4'h0, 1'b0);
        sample();
        checkOutput("full_aw_valid", 32'(mst_aw_valid), 0);
        checkOutput("full_aw_ready", 32'(aw_ready), 0);
        checkOutput("full_flag", 32'(fifo_full), 1);
        checkOutput("full_w_head", 32'(mst_w_sel), 0);
        tick();
        for (int k = 0; k < 4; k++) begin
            applyStimulus(4'h0, 1'b0, 4'hF, 4'hF, 1'b1, 4'h0, 1'b0);
            exp_w_q.push_back(k * 2 + 1);
            sample();
            tick();
        end
        applyStimulus(4'h0, 1'b0, 4'hF, 4'hF, 1'b1, 4'h0, 1'b0);
        sample();
        checkOutput("empty_w_valid", 32'(mst_w_valid), 0);
        checkOutput("empty_w_last", 32'(mst_w_last), 0);
        checkOutput("empty_w_ready", 32'(w_ready), 0);
        checkOutput("empty_fifo_full", 32'(fifo_full), 0);
        tick();

        // Lock: grant 1 held while ready is low, even when requester 0 joins.
        applyStimulus(4'h6, 1'b0, 4'h0, 4'h0, 1'b0, 4'h0, 1'b0);
        sample();
        checkOutput("lock_aw_valid", 32'(mst_aw_valid), 1);
        checkOutput("lock_aw_sel_first", 32'(mst_aw_sel), 1);
        tick();
        repeat (2) begin
            applyStimulus(4'h7, 1'b0, 4'h0, 4'h0, 1'b0, 4'h0, 1'b0);
            sample();
            checkOutput("lock_aw_sel_hold", 32'(mst_aw_sel), 1);
            tick();
        end
        applyStimulus(4'h7, 1'b1, 4'h0, 4'h0, 1'b0, 4'h0, 1'b0);
        exp_aw_q.push_back(1);
        sample();
        tick();
        applyStimulus(4'h7, 1'b1, 4'h0, 4'h0, 1'b0, 4'h0, 1'b0);
        exp_aw_q.push_back(2);
        sample();
        tick();
        applyStimulus(4'h0, 1'b0, 4'h6, 4'h6, 1'b1, 4'h0, 1'b0);
        exp_w_q.push_back(3);
        sample();
        tick();
        applyStimulus(4'h0, 1'b0, 4'h6, 4'h6, 1'b1, 4'h0, 1'b0);
        exp_w_q.push_back(5);
        sample();
        tick();

        // No W bypass, then a 3-beat burst from 0 while 3 waits its turn.
        applyStimulus(4'h1, 1'b1, 4'h1, 4'h1, 1'b1, 4'h0, 1'b0);
        exp_aw_q.push_back(0);
        sample();
        checkOutput("w_no_bypass", 32'(mst_w_valid), 0);
        tick();
        applyStimulus(4'h8, 1'b1, 4'h0, 4'h0, 1'b0, 4'h0, 1'b0);
        exp_aw_q.push_back(3);
        sample();
        tick();
        repeat (2) begin
            applyStimulus(4'h0, 1'b0, 4'h9, 4'h0, 1'b1, 4'h0, 1'b0);
            exp_w_q.push_back(0);
            sample();
            checkOutput("burst_w_ready_mid", 32'(w_ready), 1);
            tick();
        end
        applyStimulus(4'h0, 1'b0, 4'h9, 4'h9, 1'b1, 4'h0, 1'b0);
        exp_w_q.push_back(1);
        sample();
        checkOutput("burst_w_ready_last", 32'(w_ready), 1);
        tick();
        applyStimulus(4'h0, 1'b0, 4'h8, 4'h8, 1'b1, 4'h0, 1'b0);
        exp_w_q.push_back(7);
        sample();
        checkOutput("burst_next_ready", 32'(w_ready), 8);
        tick();

        // Fill to full, pop while full keeps AW blocked, AW goes the next cycle.
        for (int k = 0; k < 4; k++) begin
            applyStimulus(4'h5, 1'b1, 4'h0, 4'h0, 1'b0, 4'h0, 1'b0);
            exp_aw_q.push_back((k % 2) * 2);
            sample();
            tick();
        end
        applyStimulus(4'h2, 1'b1, 4'h0, 4'h0, 1'b0, 4'h0, 1'b0);
        sample();
        checkOutput("blocked_aw_valid", 32'(mst_aw_valid), 0);
        checkOutput("blocked_full", 32'(fifo_full), 1);
        tick();
        applyStimulus(4'h2, 1'b1, 4'h1, 4'h1, 1'b1, 4'h0, 1'b0);
        exp_w_q.push_back(1);
        sample();
        checkOutput("pop_while_full_aw_valid", 32'(mst_aw_valid), 0);
        checkOutput("pop_while_full_aw_ready", 32'(aw_ready), 0);
        tick();
        applyStimulus(4'h2, 1'b1, 4'h0, 4'h0, 1'b0, 4'h0, 1'b0);
        exp_aw_q.push_back(1);
        sample();
        checkOutput("after_pop_full", 32'(fifo_full), 0);
        tick();
        applyStimulus(4'h0, 1'b0, 4'h4, 4'h4, 1'b1, 4'h0, 1'b0);
        exp_w_q.push_back(5);
        sample();
        tick();
        applyStimulus(4'h8, 1'b1, 4'h1, 4'h1, 1'b1, 4'h0, 1'b0);
        exp_aw_q.push_back(3);
        exp_w_q.push_back(1);
        sample();
        tick();
        applyStimulus(4'h0, 1'b0, 4'h0, 4'h0, 1'b0, 4'h0, 1'b0);
        sample();
        checkOutput("push_pop_full", 32'(fifo_full), 0);
        checkOutput("push_pop_head", 32'(mst_w_sel), 2);
        tick();
        applyStimulus(4'h0, 1'b0, 4'h4, 4'h4, 1'b1, 4'h0, 1'b0);
        exp_w_q.push_back(5);
        sample();
        tick();
        applyStimulus(4'h0, 1'b0, 4'h2, 4'h2, 1'b1, 4'h0, 1'b0);
        exp_w_q.push_back(3);
        sample();
        tick();
        applyStimulus(4'h4, 1'b1, 4'h0, 4'h0, 1'b0, 4'h0, 1'b0);
        exp_aw_q.push_back(2);
        sample();
        tick();
        applyStimulus(4'h2, 1'b0, 4'h0, 4'h0, 1'b0, 4'h0, 1'b0);
        sample();
        checkOutput("pre_reset_lock_sel", 32'(mst_aw_sel), 1);
        tick();

        // Reset with two FIFO entries and the AW lock set.
        rst = 1'b1;
        applyStimulus(4'h0, 1'b0, 4'h0, 4'h0, 1'b0, 4'h0, 1'b0);
        tick();
        rst = 1'b0;
        sample();
        checkOutput("rst2_aw_valid", 32'(mst_aw_valid), 0);
        checkOutput("rst2_w_valid", 32'(mst_w_valid), 0);
        checkOutput("rst2_ar_valid", 32'(mst_ar_valid), 0);
        checkOutput("rst2_fifo_full", 32'(fifo_full), 0);
        checkOutput("rst2_aw_sel", 32'(mst_aw_sel), 0);
        checkOutput("rst2_w_sel", 32'(mst_w_sel), 0);
        tick();
        applyStimulus(4'h9, 1'b0, 4'hF, 4'hF, 1'b0, 4'h0, 1'b0);
        sample();
        checkOutput("rst2_ptr_sel", 32'(mst_aw_sel), 0);
        checkOutput("rst2_aw_valid_req", 32'(mst_aw_valid), 1);
        checkOutput("rst2_fifo_emptied", 32'(mst_w_valid), 0);
        tick();
        applyStimulus(4'h9, 1'b1, 4'h0, 4'h0, 1'b0, 4'h0, 1'b0);
        exp_aw_q.push_back(0);
        sample();
        tick();
        applyStimulus(4'h0, 1'b0, 4'h1, 4'h1, 1'b1, 4'h0, 1'b0);
        exp_w_q.push_back(1);
        sample();
        tick();

        // AR alternates 0,3 while AW runs on its own pointer.
        for (int k = 0; k < 4; k++) begin
            applyStimulus(4'hF, 1'b1, 4'h0, 4'h0, 1'b0, 4'h9, 1'b1);
            exp_aw_q.push_back((k + 1) % 4);
            exp_ar_q.push_back((k % 2 == 0) ? 0 : 3);
            sample();
            tick();
        end
        applyStimulus(4'h0, 1'b0, 4'h0, 4'h0, 1'b0, 4'h6, 1'b0);
        sample();
        checkOutput("ar_valid", 32'(mst_ar_valid), 1);
        checkOutput("ar_lock_sel", 32'(mst_ar_sel), 1);
        tick();
        applyStimulus(4'h0, 1'b0, 4'h0, 4'h0, 1'b0, 4'h7, 1'b0);
        sample();
        checkOutput("ar_lock_hold", 32'(mst_ar_sel), 1);
        tick();
        applyStimulus(4'h0, 1'b0, 4'h0, 4'h0, 1'b0, 4'h7, 1'b1);
        exp_ar_q.push_back(1);
        sample();
        tick();
        for (int k = 0; k < 4; k++) begin
            applyStimulus(4'h0, 1'b0, 4'hF, 4'hF, 1'b1, 4'h0, 1'b0);
            exp_w_q.push_back(((k + 1) % 4) * 2 + 1);
            sample();
            tick();
        end
        applyStimulus(4'h0, 1'b0, 4'h0, 4'h0, 1'b0, 4'h0, 1'b0);
        sample();
        tick();

        checkOutput("aw_queue_drained", 32'(exp_aw_q.size()), 0);
        checkOutput("ar_queue_drained", 32'(exp_ar_q.size()), 0);
        checkOutput("w_queue_drained", 32'(exp_w_q.size()), 0);

        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

endmodule
